// File: rtl/rdl_axil_slice.sv
// rtl/rdl_axil_slice.sv - AXI-Lite register slice, 2-entry skid buffer on every channel
// Define RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN to limit each direction to one outstanding transaction.

module rdl_axil_slice_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t       state;
    logic [W-1:0] skid_data;
    logic         in_acc;
    logic         out_acc;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // in_ready is registered so upstream never sees a path from out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end
                end
                FULL: begin
                    if (in_acc && out_acc) begin
                        out_data <= in_data;
                    end else if (in_acc) begin
                        state     <= SKID;
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                    end else if (out_acc) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (out_acc) begin
                        state    <= FULL;
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

module rdl_axil_slice #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_axil_awvalid,
    output logic            s_axil_awready,
    input  logic [AW-1:0]   s_axil_awaddr,
    input  logic            s_axil_wvalid,
    output logic            s_axil_wready,
    input  logic [DW-1:0]   s_axil_wdata,
    input  logic [DW/8-1:0] s_axil_wstrb,
    output logic            s_axil_bvalid,
    input  logic            s_axil_bready,
    output logic [1:0]      s_axil_bresp,
    input  logic            s_axil_arvalid,
    output logic            s_axil_arready,
    input  logic [AW-1:0]   s_axil_araddr,
    output logic            s_axil_rvalid,
    input  logic            s_axil_rready,
    output logic [DW-1:0]   s_axil_rdata,
    output logic [1:0]      s_axil_rresp,
    output logic            m_axil_awvalid,
    input  logic            m_axil_awready,
    output logic [AW-1:0]   m_axil_awaddr,
    output logic            m_axil_wvalid,
    input  logic            m_axil_wready,
    output logic [DW-1:0]   m_axil_wdata,
    output logic [DW/8-1:0] m_axil_wstrb,
    input  logic            m_axil_bvalid,
    output logic            m_axil_bready,
    input  logic [1:0]      m_axil_bresp,
    output logic            m_axil_arvalid,
    input  logic            m_axil_arready,
    output logic [AW-1:0]   m_axil_araddr,
    input  logic            m_axil_rvalid,
    output logic            m_axil_rready,
    input  logic [DW-1:0]   m_axil_rdata,
    input  logic [1:0]      m_axil_rresp
);
    localparam int WW = DW + DW / 8;
    localparam int RW = DW + 2;

    logic          aw_in_valid, aw_in_ready;
    logic          w_in_valid, w_in_ready;
    logic          ar_in_valid, ar_in_ready;
    logic [WW-1:0] w_out_data;
    logic [RW-1:0] r_out_data;

`ifdef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
    logic aw_taken, w_taken, ar_taken;

    // A response handshake clears the flag even if a new request lands the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_taken <= 1'b0;
            w_taken  <= 1'b0;
            ar_taken <= 1'b0;
        end else begin
            if (s_axil_bvalid && s_axil_bready) begin
                aw_taken <= 1'b0;
                w_taken  <= 1'b0;
            end else begin
                if (s_axil_awvalid && s_axil_awready) aw_taken <= 1'b1;
                if (s_axil_wvalid && s_axil_wready) w_taken <= 1'b1;
            end
            if (s_axil_rvalid && s_axil_rready) ar_taken <= 1'b0;
            else if (s_axil_arvalid && s_axil_arready) ar_taken <= 1'b1;
        end
    end

    assign aw_in_valid    = s_axil_awvalid & ~aw_taken;
    assign w_in_valid     = s_axil_wvalid & ~w_taken;
    assign ar_in_valid    = s_axil_arvalid & ~ar_taken;
    assign s_axil_awready = aw_in_ready & ~aw_taken;
    assign s_axil_wready  = w_in_ready & ~w_taken;
    assign s_axil_arready = ar_in_ready & ~ar_taken;
`else
    assign aw_in_valid    = s_axil_awvalid;
    assign w_in_valid     = s_axil_wvalid;
    assign ar_in_valid    = s_axil_arvalid;
    assign s_axil_awready = aw_in_ready;
    assign s_axil_wready  = w_in_ready;
    assign s_axil_arready = ar_in_ready;
`endif

    rdl_axil_slice_skid #(.W(AW)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(aw_in_valid), .in_ready(aw_in_ready), .in_data(s_axil_awaddr),
        .out_valid(m_axil_awvalid), .out_ready(m_axil_awready), .out_data(m_axil_awaddr)
    );

    rdl_axil_slice_skid #(.W(WW)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data({s_axil_wdata, s_axil_wstrb}),
        .out_valid(m_axil_wvalid), .out_ready(m_axil_wready), .out_data(w_out_data)
    );
    assign {m_axil_wdata, m_axil_wstrb} = w_out_data;

    rdl_axil_slice_skid #(.W(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(m_axil_bvalid), .in_ready(m_axil_bready), .in_data(m_axil_bresp),
        .out_valid(s_axil_bvalid), .out_ready(s_axil_bready), .out_data(s_axil_bresp)
    );

    rdl_axil_slice_skid #(.W(AW)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(ar_in_valid), .in_ready(ar_in_ready), .in_data(s_axil_araddr),
        .out_valid(m_axil_arvalid), .out_ready(m_axil_arready), .out_data(m_axil_araddr)
    );

    rdl_axil_slice_skid #(.W(RW)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(m_axil_rvalid), .in_ready(m_axil_rready), .in_data({m_axil_rdata, m_axil_rresp}),
        .out_valid(s_axil_rvalid), .out_ready(s_axil_rready), .out_data(r_out_data)
    );
    assign {s_axil_rdata, s_axil_rresp} = r_out_data;
endmodule

// File: tb/tb_rdl_axil_slice.sv
// tb/tb_rdl_axil_slice.sv - randomized and directed checks of rdl_axil_slice against a FIFO model
// Honours RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN when defined.

module tb_rdl_axil_slice;
    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R
    logic        tb_in_v [5];
    logic [39:0] tb_in_d [5];
    logic        tb_out_r [5];

    logic            s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
    logic [1:0]      s_axil_bresp, s_axil_rresp;
    logic [DW-1:0]   s_axil_rdata, m_axil_wdata;
    logic [DW/8-1:0] m_axil_wstrb;
    logic            m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic [AW-1:0]   m_axil_awaddr, m_axil_araddr;

    rdl_axil_slice #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(tb_in_v[0]), .s_axil_awready(s_axil_awready), .s_axil_awaddr(tb_in_d[0][5:0]),
        .s_axil_wvalid(tb_in_v[1]), .s_axil_wready(s_axil_wready),
        .s_axil_wdata(tb_in_d[1][35:4]), .s_axil_wstrb(tb_in_d[1][3:0]),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(tb_out_r[2]), .s_axil_bresp(s_axil_bresp),
        .s_axil_arvalid(tb_in_v[3]), .s_axil_arready(s_axil_arready), .s_axil_araddr(tb_in_d[3][5:0]),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(tb_out_r[4]),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(tb_out_r[0]), .m_axil_awaddr(m_axil_awaddr),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(tb_out_r[1]),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_bvalid(tb_in_v[2]), .m_axil_bready(m_axil_bready), .m_axil_bresp(tb_in_d[2][1:0]),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(tb_out_r[3]), .m_axil_araddr(m_axil_araddr),
        .m_axil_rvalid(tb_in_v[4]), .m_axil_rready(m_axil_rready),
        .m_axil_rdata(tb_in_d[4][33:2]), .m_axil_rresp(tb_in_d[4][1:0])
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic string chn(input int c);
        case (c)
            0: return "aw";
            1: return "w";
            2: return "b";
            3: return "ar";
            default: return "r";
        endcase
    endfunction

    function automatic logic [39:0] mask(input int c);
        int w;
        case (c)
            0, 3: w = 6;
            1: w = 36;
            2: w = 2;
            default: w = 34;
        endcase
        return (40'd1 << w) - 40'd1;
    endfunction

    function automatic logic [39:0] rnd(input int c);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0] & mask(c);
    endfunction

    function automatic logic dut_in_ready(input int c);
        case (c)
            0: return s_axil_awready;
            1: return s_axil_wready;
            2: return m_axil_bready;
            3: return s_axil_arready;
            default: return m_axil_rready;
        endcase
    endfunction

    function automatic logic dut_out_valid(input int c);
        case (c)
            0: return m_axil_awvalid;
            1: return m_axil_wvalid;
            2: return s_axil_bvalid;
            3: return m_axil_arvalid;
            default: return s_axil_rvalid;
        endcase
    endfunction

    function automatic logic [39:0] dut_out_data(input int c);
        case (c)
            0: return 40'(m_axil_awaddr);
            1: return 40'({m_axil_wdata, m_axil_wstrb});
            2: return 40'(s_axil_bresp);
            3: return 40'(m_axil_araddr);
            default: return 40'({s_axil_rdata, s_axil_rresp});
        endcase
    endfunction

    // Model: each channel is a 2-deep FIFO with 1-cycle latency and a ready that reflects its fill.
    int          mcnt [5];
    logic [39:0] mdat [5][2];
    bit          acc_in [5];
    bit          acc_out [5];
    bit          rst_seen = 1'b1;
    bit          started = 1'b0;
`ifdef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
    bit aw_t = 1'b0, w_t = 1'b0, ar_t = 1'b0;
`endif

    function automatic bit exp_in_ready(input int c);
        bit r;
        r = !rst_seen && (mcnt[c] < 2);
`ifdef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
        if ((c == 0 && aw_t) || (c == 1 && w_t) || (c == 3 && ar_t)) r = 1'b0;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 5; c++) begin
                mcnt[c]    = 0;
                acc_in[c]  = 1'b0;
                acc_out[c] = 1'b0;
            end
            rst_seen = 1'b1;
`ifdef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
            aw_t = 1'b0; w_t = 1'b0; ar_t = 1'b0;
`endif
        end else begin
            for (int c = 0; c < 5; c++) begin
                acc_in[c]  = tb_in_v[c] && exp_in_ready(c);
                acc_out[c] = (mcnt[c] > 0) && tb_out_r[c];
            end
`ifdef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
            if (acc_out[2]) begin
                aw_t = 1'b0; w_t = 1'b0;
            end else begin
                if (acc_in[0]) aw_t = 1'b1;
                if (acc_in[1]) w_t = 1'b1;
            end
            if (acc_out[4]) ar_t = 1'b0;
            else if (acc_in[3]) ar_t = 1'b1;
`endif
            for (int c = 0; c < 5; c++) begin
                if (acc_out[c]) begin
                    mdat[c][0] = mdat[c][1];
                    mcnt[c]--;
                end
                if (acc_in[c]) begin
                    mdat[c][mcnt[c]] = tb_in_d[c];
                    mcnt[c]++;
                end
            end
            rst_seen = 1'b0;
        end
        started = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < 5; c++) begin
                chk({chn(c), "_in_ready"}, 40'(dut_in_ready(c)), 40'(exp_in_ready(c)));
                chk({chn(c), "_out_valid"}, 40'(dut_out_valid(c)), 40'(mcnt[c] > 0));
                if (mcnt[c] > 0) chk({chn(c), "_payload"}, dut_out_data(c), mdat[c][0]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int c = 0; c < 5; c++) begin
            tb_in_v[c]  = 1'b0;
            tb_out_r[c] = 1'b1;
        end
        repeat (4) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, k, got, n_in, n_out, first, last, ntx;
        for (int c = 0; c < 5; c++) begin
            tb_in_v[c]  = 1'b0;
            tb_in_d[c]  = '0;
            tb_out_r[c] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) step();
        chk("reset_awready", 40'(s_axil_awready), 0);
        chk("reset_bready", 40'(m_axil_bready), 0);
        chk("reset_awvalid", 40'(m_axil_awvalid), 0);
        rst = 1'b0;
        step();
        chk("release_awready", 40'(s_axil_awready), 1);
        chk("release_rready", 40'(m_axil_rready), 1);

        // single write and its response
        idle();
        tb_in_v[0] = 1'b1; tb_in_d[0] = 40'h14;
        tb_in_v[1] = 1'b1; tb_in_d[1] = {4'h0, 32'hDEADBEEF, 4'hF};
        step();
        tb_in_v[0] = 1'b0; tb_in_v[1] = 1'b0;
        chk("t1_awvalid", 40'(m_axil_awvalid), 1);
        chk("t1_awaddr", 40'(m_axil_awaddr), 40'h14);
        chk("t1_wdata", 40'(m_axil_wdata), 40'hDEADBEEF);
        chk("t1_wstrb", 40'(m_axil_wstrb), 40'hF);
        tb_in_v[2] = 1'b1; tb_in_d[2] = 40'h0;
        step();
        tb_in_v[2] = 1'b0;
        chk("t1_bvalid", 40'(s_axil_bvalid), 1);
        chk("t1_bresp", 40'(s_axil_bresp), 0);
        step();

`ifndef RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN
        // back-to-back reads into a stalled bridge
        idle();
        tb_out_r[3] = 1'b0;
        tb_in_v[3] = 1'b1; tb_in_d[3] = 40'h0;
        n = 0; k = 0;
        while (n < 2 && k < 10) begin
            step(); k++;
            if (acc_in[3]) begin
                n++;
                tb_in_d[3] = 40'(4 * n);
            end
        end
        chk("t2_arready_after_2nd", 40'(s_axil_arready), 0);
        chk("t2_araddr_stall", 40'(m_axil_araddr), 40'h0);
        step();
        chk("t2_araddr_stall2", 40'(m_axil_araddr), 40'h0);
        tb_out_r[3] = 1'b1;
        got = 0; k = 0;
        while (got < 3 && k < 20) begin
            if (acc_in[3]) tb_in_v[3] = 1'b0;
            if (m_axil_arvalid) begin
                chk($sformatf("t2_order%0d", got), 40'(m_axil_araddr), 40'(4 * got));
                got++;
            end
            step(); k++;
        end
        tb_in_v[3] = 1'b0;
        chk("t2_read_count", 40'(got), 3);

        // 16-beat AW+W stream
        idle();
        tb_in_v[0] = 1'b1; tb_in_v[1] = 1'b1;
        tb_in_d[0] = 40'h0; tb_in_d[1] = rnd(1);
        n_in = 0; n_out = 0; first = -1; last = -1; k = 0;
        while (n_out < 16 && k < 40) begin
            step(); k++;
            if (acc_in[0]) begin
                n_in++;
                tb_in_d[0] = 40'((4 * n_in) & 63);
                tb_in_d[1] = rnd(1);
                if (n_in == 16) begin
                    tb_in_v[0] = 1'b0; tb_in_v[1] = 1'b0;
                end
            end
            if (acc_out[0]) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_out++;
            end
        end
        tb_in_v[0] = 1'b0; tb_in_v[1] = 1'b0;
        chk("t3_beats", 40'(n_out), 16);
        chk("t3_span", 40'(last - first), 15);
`else
        // second request held off until the response handshake
        idle();
        tb_in_v[0] = 1'b1; tb_in_d[0] = 40'h20;
        tb_in_v[1] = 1'b1; tb_in_d[1] = rnd(1);
        step();
        tb_in_d[0] = 40'h24; tb_in_v[1] = 1'b0;
        repeat (3) begin
            step();
            chk("t6_awready_blocked", 40'(s_axil_awready), 0);
        end
        tb_in_v[2] = 1'b1; tb_in_d[2] = 40'h0;
        step();
        tb_in_v[2] = 1'b0;
        chk("t6_bvalid", 40'(s_axil_bvalid), 1);
        chk("t6_awready_during_b", 40'(s_axil_awready), 0);
        step();
        chk("t6_awready_after_b", 40'(s_axil_awready), 1);
        step();
        tb_in_v[0] = 1'b0;

        idle();
        tb_in_v[3] = 1'b1; tb_in_d[3] = 40'h08;
        step();
        tb_in_d[3] = 40'h0C;
        repeat (3) begin
            step();
            chk("t6_arready_blocked", 40'(s_axil_arready), 0);
        end
        tb_in_v[4] = 1'b1; tb_in_d[4] = rnd(4);
        step();
        tb_in_v[4] = 1'b0;
        chk("t6_rvalid", 40'(s_axil_rvalid), 1);
        chk("t6_arready_during_r", 40'(s_axil_arready), 0);
        step();
        chk("t6_arready_after_r", 40'(s_axil_arready), 1);
        step();
        tb_in_v[3] = 1'b0;
`endif

        // reset while the R buffer holds two beats
        idle();
        tb_out_r[4] = 1'b0;
        tb_in_v[4] = 1'b1; tb_in_d[4] = rnd(4);
        n = 0; k = 0;
        while (n < 2 && k < 10) begin
            step(); k++;
            if (acc_in[4]) begin
                n++;
                tb_in_d[4] = rnd(4);
            end
        end
        tb_in_v[4] = 1'b0;
        chk("t5_skid_rready", 40'(m_axil_rready), 0);
        chk("t5_skid_rvalid", 40'(s_axil_rvalid), 1);
        rst = 1'b1;
        step();
        chk("t5_rst_rvalid", 40'(s_axil_rvalid), 0);
        chk("t5_rst_rready", 40'(m_axil_rready), 0);
        chk("t5_rst_arready", 40'(s_axil_arready), 0);
        step();
        rst = 1'b0;
        step();
        chk("t5_release_rready", 40'(m_axil_rready), 1);
        chk("t5_release_awready", 40'(s_axil_awready), 1);
        chk("t5_release_rvalid", 40'(s_axil_rvalid), 0);

        // random traffic on all channels
        ntx = 0; k = 0;
        while (ntx < 1000 && k < 30000) begin
            for (int c = 0; c < 5; c++) begin
                if (!tb_in_v[c] || acc_in[c]) begin
                    tb_in_v[c] = ($urandom_range(0, 9) < 7);
                    tb_in_d[c] = rnd(c);
                end
                tb_out_r[c] = ($urandom_range(0, 9) < 7);
            end
            step(); k++;
            if (acc_in[0]) ntx++;
            if (acc_in[3]) ntx++;
        end
        chk("t4_random_tx_done", 40'(ntx >= 1000), 1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rdl_axil_slice.md
Name: rdl_axil_slice

Overview:
- Full-throughput AXI-Lite register slice that sits directly upstream of the AXI-Lite-to-register-bus bridge.
- The CPU/interconnect connects to the s_axil_* side; the bridge connects to the m_axil_* side.
- Registers all five channels with 2-entry skid buffers, which breaks timing paths between the interconnect and the bridge in both directions.
- Optionally limits the design to one outstanding transaction per direction. The bridge drops or merges responses under back-to-back traffic while B/R are stalled, so this limit protects it.

Parameters:
- AW, 6: address width, same for all address channels.
- DW, 32: data width; must be a multiple of 8; strobe width is DW/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axil_awvalid/awready/awaddr  in/out/in  1/1/AW  upstream write address
- s_axil_wvalid/wready/wdata/wstrb  in/out/in/in  1/1/DW/DW/8  upstream write data
- s_axil_bvalid/bready/bresp  out/in/out  1/1/2  upstream write response
- s_axil_arvalid/arready/araddr  in/out/in  1/1/AW  upstream read address
- s_axil_rvalid/rready/rdata/rresp  out/in/out/out  1/1/DW/2  upstream read data
- m_axil_awvalid/awready/awaddr  out/in/out  1/1/AW  to bridge
- m_axil_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DW/DW/8  to bridge
- m_axil_bvalid/bready/bresp  in/out/in  1/1/2  from bridge
- m_axil_arvalid/arready/araddr  out/in/out  1/1/AW  to bridge
- m_axil_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DW/2  from bridge

Behaviour:
Skid buffer, five identical instances:
- Each channel uses one skid buffer. AW/W/AR run s->m; B/R run m->s.
- Payload is the channel's non-handshake signals.
- Storage per buffer: main register (drives out_valid/out payload) and skid register.
- States: EMPTY (main invalid), FULL (main valid, skid invalid), SKID (both valid).
- in_ready is a flop: in_ready = not skid_valid next cycle; it is never a combinational function of out_ready.
- Transitions:
  - EMPTY + in accept -> FULL (load main).
  - FULL + in accept + out accept -> FULL (load main).
  - FULL + in accept, no out accept -> SKID (load skid, in_ready drops next cycle).
  - FULL + out accept, no in -> EMPTY.
  - SKID + out accept -> FULL (skid moves to main, in_ready rises next cycle).
- Timing:
  - Latency: in handshake at cycle N gives out_valid at N+1.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
- Output rules:
  - out_valid/payload stay stable while out_valid and not out_ready.
  - Order is preserved.
  - Payload is passed bit-exact; wstrb and resp are not altered.
- Reset:
  - All valids = 0 and all in_ready = 0 while rst is high.
  - All in_ready = 1 in the first cycle after rst is released.
  - Payload registers reset to 0.
  - rst mid-transfer discards buffered beats; no recovery.

Optional Feature:
- Macro RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN.
- Defined:
  - Flags aw_taken/w_taken set on the s-side AW/W handshakes. While set, s_axil_awready/wready are held 0.
  - Both flags clear on the s-side B handshake (s_axil_bvalid & s_axil_bready).
  - Flag ar_taken behaves the same way: it gates s_axil_arready and clears on the s-side R handshake.
  - A clear and a new request in the same cycle: the clear wins; the new request is accepted no earlier than the next cycle.
  - Flags reset to 0.
- Undefined: flags absent; full throughput.

Test Plan:
1. Single write, awaddr=0x14, wdata=0xDEADBEEF, wstrb=0xF, m ready held 1 -> m_axil_aw/w valid 1 cycle later with identical values. m_axil_bvalid with bresp=0 -> s_axil_bvalid next cycle, bresp=0.
2. Back-to-back reads 0x00, 0x04, 0x08 with m_axil_arready=0 for 3 cycles -> s_axil_arready drops after the 2nd accept. m_axil_araddr holds 0x00 while stalled. After release, the order is 0x00, 0x04, 0x08 with no loss or duplication.
3. Streaming 16 AW+W beats with m ready always 1 -> 16 m-side handshakes in 16 consecutive cycles.
4. Random ready/valid on all channels, 1000 transactions -> m-side sequence equals s-side sequence. No valid drops or payload changes while stalled.
5. rst asserted while the SKID state holds 2 beats -> all valids 0 next cycle. Readies are 0 during rst and 1 the cycle after release.
6. With RDL_AXIL_SLICE_SINGLE_OUTSTANDING_EN: 2nd AW offered before the 1st B -> s_axil_awready=0 until the cycle after the s-side B handshake. The same check applies to AR vs R.
